// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types, constants and scan-classification helpers for the keypad scanner
package keypad_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESS_WAIT,
        S_HELD,
        S_RELEASE_WAIT
    } kp_state_t;

    typedef enum logic [1:0] {
        NONE,
        SINGLE,
        MULTI
    } scan_res_t;

    localparam logic [3:0] COL_RESET = 4'b1110;

    // Ghosting shows up as two or more bits, so only the count matters here
    function automatic scan_res_t classify(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) n = n + 5'(v[i]);
        return (n == 5'd0) ? NONE : (n == 5'd1) ? SINGLE : MULTI;
    endfunction

    // Bit index doubles as the key code because bits are laid out {row, col}
    function automatic logic [3:0] key_of(input logic [15:0] v);
        logic [3:0] k;
        k = '0;
        for (int i = 15; i >= 0; i--) if (v[i]) k = 4'(i);
        return k;
    endfunction

endpackage

// File: rtl/keypad_if.sv
// keypad_if: keypad pins plus the debounced key report towards the time-set logic
interface keypad_if;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (
        input  row,
        output col,
        output key_code,
        output key_valid,
        output key_held
    );

    modport slave (
        output row,
        input  col,
        input  key_code,
        input  key_valid,
        input  key_held
    );
endinterface

// File: rtl/keypad_sync.sv
// keypad_sync: 2-flop synchronizer for the asynchronous row lines, idles at "no key"
module keypad_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] d,
    output logic [3:0] q
);
    logic [3:0] meta;

    // Two-stage capture; reset to all-ones so nothing looks pressed after reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 4'b1111;
            q    <= 4'b1111;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: rotating column strobe, per-scan key classification and press/release debounce
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 1024,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic     clk,
    input  logic     rst,
    keypad_if.master kp
);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

    logic [SW-1:0] slot;
    logic [1:0]    col_idx;
    logic [15:0]   acc;
    logic [15:0]   pressed;
    logic [3:0]    row_s;
    logic          slot_last;
    logic          scan_end;
    scan_res_t     res;
    logic [3:0]    key;
    logic          is_cand;
    logic          is_code;
    kp_state_t     state, state_n;
    logic [3:0]    cand, cand_n;
    logic [CW-1:0] cnt, cnt_n, cnt_inc;
    logic [3:0]    code_n;
    logic          valid_n;

    keypad_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (kp.row),
        .q   (row_s)
    );

    assign slot_last = slot == SW'(SCAN_DIV - 1);
    assign scan_end  = slot_last && col_idx == 2'd3;
    assign res       = classify(pressed);
    assign key       = key_of(pressed);
    assign is_cand   = res == SINGLE && key == cand;
    assign is_code   = res == SINGLE && key == kp.key_code;
    assign cnt_inc   = cnt + CW'(1);
    assign kp.key_held = state == S_HELD || state == S_RELEASE_WAIT;

    // Merge the current column's sample so scan end sees all 16 keys in the same cycle
    always_comb begin
        pressed = acc;
        for (int r = 0; r < 4; r++) pressed[{r[1:0], col_idx}] = ~row_s[r];
    end

    // Slot timing, column rotation and row capture on the last cycle of each slot
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot    <= '0;
            col_idx <= '0;
            kp.col  <= COL_RESET;
            acc     <= '0;
        end else begin
            slot <= slot_last ? '0 : slot + SW'(1);
            if (slot_last) begin
                col_idx <= col_idx + 2'd1;
                kp.col  <= {kp.col[2:0], kp.col[3]};
                acc     <= pressed;
            end
        end
    end

    // Debounce decisions, taken only once per full scan
    always_comb begin
        state_n = state;
        cand_n  = cand;
        cnt_n   = cnt;
        code_n  = kp.key_code;
        valid_n = 1'b0;
        if (scan_end) begin
            case (state)
                S_IDLE: begin
                    if (res == SINGLE) begin
                        state_n = S_PRESS_WAIT;
                        cand_n  = key;
                        cnt_n   = CW'(1);
                    end
                end
                S_PRESS_WAIT: begin
                    if (is_cand) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc == CW'(DEBOUNCE_SCANS)) begin
                            state_n = S_HELD;
                            code_n  = cand;
                            valid_n = 1'b1;
                        end
                    end else if (res == SINGLE) begin
                        cand_n = key;
                        cnt_n  = CW'(1);
                    end else begin
                        state_n = S_IDLE;
                    end
                end
                S_HELD: begin
                    if (!is_code) begin
                        state_n = S_RELEASE_WAIT;
                        cnt_n   = CW'(1);
                    end
                end
                S_RELEASE_WAIT: begin
                    if (is_code) begin
                        state_n = S_HELD;
                    end else begin
                        cnt_n = cnt_inc;
                        if (cnt_inc == CW'(DEBOUNCE_SCANS)) state_n = S_IDLE;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    // FSM state, debounce bookkeeping and the registered key report
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            cand         <= '0;
            cnt          <= '0;
            kp.key_code  <= '0;
            kp.key_valid <= 1'b0;
        end else begin
            state        <= state_n;
            cand         <= cand_n;
            cnt          <= cnt_n;
            kp.key_code  <= code_n;
            kp.key_valid <= valid_n;
        end
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: scan-aligned keypad stimulus, scoreboard on key_valid, reference debounce model
module tb_keypad_scanner;
    localparam int D    = 3;
    localparam int SD   = 8;
    localparam int SCAN = 4 * SD;

    typedef struct {
        int code;
        int scan;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] mask = '0;
    exp_t        q[$];
    exp_t        e;
    time         end_t[512];
    int          scan_no = 0;
    int          checks = 0;
    int          fails = 0;
    logic        prev_v = 1'b0;
    int          held = -1;
    int          cand = -1;
    int          run = 0;
    int          gone = 0;
    int          code = 0;
    int          rk;
    int          rsel;
    logic [15:0] rm;
    logic [3:0]  rot[4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

    keypad_if kif ();

    keypad_scanner #(
        .SCAN_DIV       (SD),
        .DEBOUNCE_SCANS (D)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kif)
    );

    always #5 clk = ~clk;

    // Physical keypad: a pressed key shorts its row to its column when that column is strobed
    always_comb begin
        for (int r = 0; r < 4; r++) kif.row[r] = ~|(mask[r*4 +: 4] & ~kif.col);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one call per full scan with the set of keys held during that scan
    task automatic model_step(input logic [15:0] m);
        int k;
        k = -1;
        if ($countones(m) == 1)
            for (int i = 0; i < 16; i++) if (m[i]) k = i;
        if (held < 0) begin
            if (k >= 0) begin
                if (k == cand) run++;
                else begin
                    cand = k;
                    run  = 1;
                end
                if (run == D) begin
                    held = k;
                    code = k;
                    gone = 0;
                    cand = -1;
                    run  = 0;
                    q.push_back('{k, scan_no});
                end
            end else begin
                cand = -1;
                run  = 0;
            end
        end else if (k == held) begin
            gone = 0;
        end else begin
            gone++;
            if (gone == D) begin
                held = -1;
                gone = 0;
            end
        end
    endtask

    task automatic do_scan(input logic [15:0] m);
        @(negedge clk);
        mask = m;
        scan_no++;
        model_step(m);
        repeat (SCAN) @(posedge clk);
        end_t[scan_no] = $time;
        #1;
        check("scan_held", kif.key_held, held >= 0);
        check("scan_code", kif.key_code, code);
    endtask

    // Asserts reset immediately (between clock edges), checks outputs, then watches one idle scan
    task automatic reset_phase();
        rst = 1'b0;
        #1;
        check("rst_col", kif.col, 4'b1110);
        check("rst_valid", kif.key_valid, 0);
        check("rst_held", kif.key_held, 0);
        check("rst_code", kif.key_code, 0);
        check("rst_pending", q.size(), 0);
        q.delete();
        held = -1;
        cand = -1;
        run  = 0;
        gone = 0;
        code = 0;
        mask = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            repeat (SD) @(posedge clk);
            #1;
            check("col_rot", kif.col, rot[i]);
        end
    endtask

    // Scoreboard monitor: every key_valid pulse must match the oldest expected acceptance
    always @(negedge clk) begin
        if (kif.key_valid) begin
            check("valid_width", prev_v, 0);
            if (q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL spurious_valid: got code %0h with nothing expected at %0t", kif.key_code, $time);
            end else begin
                e = q.pop_front();
                check("valid_code", kif.key_code, e.code);
                check("valid_time", 32'($time - end_t[e.scan]), 5);
                check("valid_held", kif.key_held, 1);
            end
        end
        prev_v = kif.key_valid;
    end

    initial begin
        #2;
        reset_phase();
        repeat (5) do_scan(16'h0200);
        repeat (3) do_scan(16'h0000);
        repeat (2) do_scan(16'h0200);
        do_scan(16'h0000);
        repeat (3) do_scan(16'h0200);
        do_scan(16'h0000);
        repeat (2) do_scan(16'h0200);
        repeat (3) do_scan(16'h0000);
        repeat (6) do_scan(16'h0021);
        do_scan(16'h0000);
        repeat (3) do_scan(16'h0200);
        repeat (6) do_scan(16'h0040);
        repeat (3) do_scan(16'h0000);
        repeat (4) do_scan(16'h0040);
        @(negedge clk);
        repeat (13) @(posedge clk);
        #3;
        reset_phase();
        rk = 9;
        repeat (40) begin
            rsel = $urandom_range(0, 9);
            if (rsel < 2) begin
                rm = '0;
            end else if (rsel < 8) begin
                if ($urandom_range(0, 4) == 0) rk = $urandom_range(0, 15);
                rm = 16'(1) << rk;
            end else begin
                rm = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
            end
            do_scan(rm);
        end
        repeat (D + 1) do_scan(16'h0000);
        @(negedge clk);
        check("final_pending", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
